// File: rtl/traffic_ctrl_n_if.sv
// traffic_ctrl_n_if: sensor and light bundle between a traffic_ctrl_n
// controller (master) and its environment (slave).
// Optional macro TRAFFIC_PREEMPT_EN adds the emergency preemption pair.
interface traffic_ctrl_n_if #(
    parameter int NUM_DIR = 4,
    parameter int IW      = (NUM_DIR <= 2) ? 1 : $clog2(NUM_DIR)
);
    logic [NUM_DIR-1:0]   t;
    logic [2*NUM_DIR-1:0] lights;
    logic [IW-1:0]        green_idx;
    logic                 phase_start;
`ifdef TRAFFIC_PREEMPT_EN
    logic                 emerg;
    logic [IW-1:0]        emerg_dir;
`endif

    modport master (
        input  t,
`ifdef TRAFFIC_PREEMPT_EN
        input  emerg,
        input  emerg_dir,
`endif
        output lights,
        output green_idx,
        output phase_start
    );

    modport slave (
        output t,
`ifdef TRAFFIC_PREEMPT_EN
        output emerg,
        output emerg_dir,
`endif
        input  lights,
        input  green_idx,
        input  phase_start
    );
endinterface

// File: rtl/traffic_ctrl_n.sv
// traffic_ctrl_n: round-robin N-direction traffic light controller with
// minimum/maximum green, yellow and all-red dwell times.
// Optional macro TRAFFIC_PREEMPT_EN enables emergency preemption
// (bus.emerg / bus.emerg_dir).
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_GREEN  | green_idx shows green, sensors sampled for demand
// S_YELLOW | green_idx shows yellow for YELLOW_CYCLES cycles
// S_ALLRED | every direction red for ALLRED_CYCLES cycles (skipped if 0)
module traffic_ctrl_n #(
    parameter int NUM_DIR       = 4,
    parameter int GREEN_MIN     = 4,
    parameter int GREEN_MAX     = 10,
    parameter int YELLOW_CYCLES = 2,
    parameter int ALLRED_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    traffic_ctrl_n_if.master  bus
);
    localparam int IW   = (NUM_DIR <= 2) ? 1 : $clog2(NUM_DIR);
    localparam int MAXA = (GREEN_MAX > YELLOW_CYCLES) ? GREEN_MAX : YELLOW_CYCLES;
    localparam int MAXV = (MAXA > ALLRED_CYCLES) ? MAXA : ALLRED_CYCLES;
    localparam int CW   = $clog2(MAXV + 1);

    localparam logic [1:0] S_GREEN  = 2'd0;
    localparam logic [1:0] S_YELLOW = 2'd1;
    localparam logic [1:0] S_ALLRED = 2'd2;

    localparam logic [1:0] L_GREEN  = 2'b00;
    localparam logic [1:0] L_YELLOW = 2'b01;
    localparam logic [1:0] L_RED    = 2'b10;

    localparam logic [2*NUM_DIR-1:0] RST_LIGHTS = {{(NUM_DIR-1){L_RED}}, L_GREEN};

    logic [1:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        green_idx_q, green_idx_d;
    logic [IW-1:0]        next_idx_q, next_idx_d;
    logic                 phase_start_q, phase_start_d;
    logic [2*NUM_DIR-1:0] lights_q, lights_d;

    logic [IW-1:0]        rr_idx;
    logic                 other;
    logic                 own_car;
    logic                 em_hold;
    logic                 em_go;

    // Find the first waiting direction after the owner, wrapping around.
    always_comb begin
        rr_idx  = green_idx_q;
        other   = 1'b0;
        own_car = bus.t[green_idx_q];
        for (int i = NUM_DIR - 1; i >= 1; i--) begin
            if (bus.t[(int'(green_idx_q) + i) % NUM_DIR]) begin
                rr_idx = IW'((int'(green_idx_q) + i) % NUM_DIR);
                other  = 1'b1;
            end
        end
    end

    // Emergency qualifiers: hold the current green or force it to end.
    always_comb begin
`ifdef TRAFFIC_PREEMPT_EN
        em_hold = bus.emerg && (bus.emerg_dir == green_idx_q);
        em_go   = bus.emerg && (bus.emerg_dir != green_idx_q);
`else
        em_hold = 1'b0;
        em_go   = 1'b0;
`endif
    end

    // Phase sequencing and dwell timing.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        green_idx_d = green_idx_q;
        next_idx_d  = next_idx_q;
        case (state_q)
            S_GREEN: begin
                if (em_go) begin
                    state_d = S_YELLOW;
                    cnt_d   = '0;
`ifdef TRAFFIC_PREEMPT_EN
                    next_idx_d = bus.emerg_dir;
`endif
                end else if (!em_hold && other &&
                             ((cnt_q >= CW'(GREEN_MIN - 1) && !own_car) ||
                              cnt_q == CW'(GREEN_MAX - 1))) begin
                    state_d    = S_YELLOW;
                    cnt_d      = '0;
                    next_idx_d = rr_idx;
                end else if (cnt_q < CW'(GREEN_MAX - 1)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_YELLOW: begin
`ifdef TRAFFIC_PREEMPT_EN
                if (bus.emerg) next_idx_d = bus.emerg_dir;
`endif
                if (cnt_q == CW'(YELLOW_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (ALLRED_CYCLES > 0) begin
                        state_d = S_ALLRED;
                    end else begin
                        state_d     = S_GREEN;
                        green_idx_d = next_idx_d;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ALLRED: begin
`ifdef TRAFFIC_PREEMPT_EN
                if (bus.emerg) next_idx_d = bus.emerg_dir;
`endif
                if (cnt_q == CW'(ALLRED_CYCLES - 1)) begin
                    cnt_d       = '0;
                    state_d     = S_GREEN;
                    green_idx_d = next_idx_d;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_GREEN;
                cnt_d   = '0;
            end
        endcase
    end

    // Registered Moore outputs derived from the next state.
    always_comb begin
        phase_start_d = (state_d == S_GREEN) && (state_q != S_GREEN);
        lights_d      = {NUM_DIR{L_RED}};
        if (state_d == S_GREEN) begin
            lights_d[2*int'(green_idx_d) +: 2] = L_GREEN;
        end else if (state_d == S_YELLOW) begin
            lights_d[2*int'(green_idx_d) +: 2] = L_YELLOW;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_GREEN;
            cnt_q         <= '0;
            green_idx_q   <= '0;
            next_idx_q    <= '0;
            phase_start_q <= 1'b0;
            lights_q      <= RST_LIGHTS;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            green_idx_q   <= green_idx_d;
            next_idx_q    <= next_idx_d;
            phase_start_q <= phase_start_d;
            lights_q      <= lights_d;
        end
    end

    assign bus.lights      = lights_q;
    assign bus.green_idx   = green_idx_q;
    assign bus.phase_start = phase_start_q;
endmodule

// File: doc/traffic_ctrl_n.md
Name: traffic_ctrl_n

Overview:
- Parametrised successor to the two-road traffic-light FSM.
- Serves NUM_DIR approach directions, one green at a time, using per-direction car sensors.
- Programmable minimum-green, maximum-green, yellow and all-red dwell times.
- Round-robin service of pending demand; NUM_DIR=2 covers the original two-road intersection.

Parameters:
- NUM_DIR, 4, number of directions (2..8).
- GREEN_MIN, 4, minimum green dwell in cycles (>=1).
- GREEN_MAX, 10, maximum green dwell when other demand exists (>=GREEN_MIN).
- YELLOW_CYCLES, 2, yellow dwell in cycles (>=1).
- ALLRED_CYCLES, 1, all-red clearance in cycles (0 = phase skipped).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- t  in  NUM_DIR  car-present sensor per direction; bit k = direction k.
- lights  out  2*NUM_DIR  light for direction k at [2k+1:2k]; 00 green, 01 yellow, 10 red (11 never driven).
- green_idx  out  max(1,$clog2(NUM_DIR))  index of the direction currently owning the phase.
- phase_start  out  1  one-cycle pulse in the first cycle of every new green.

Behaviour:
- Single clock. Reset is synchronous and active-high. All outputs are registered Moore outputs of state.
- Reset values:
  - state GREEN, green_idx 0, dwell counter 0, next_idx 0, phase_start 0.
  - lights: direction 0 = 00, all other directions = 10.
- States: GREEN, YELLOW, ALLRED.
- Dwell counter: width $clog2(max(GREEN_MAX,YELLOW_CYCLES,ALLRED_CYCLES)+1). Clears on every state entry and increments each cycle in-state. It never wraps, because every state exits before the counter reaches its cap.
- Light mapping:
  - GREEN: lights[green_idx] = 00.
  - YELLOW: lights[green_idx] = 01.
  - ALLRED: all directions 10.
  - Every non-owning direction is always 10.
- Demand definition: other = |(t & ~onehot(green_idx)).
- GREEN -> YELLOW at an edge when other=1 and either:
  - cnt >= GREEN_MIN-1 and t[green_idx]=0 (gap-out), or
  - cnt == GREEN_MAX-1 (max-out).
- GREEN with other=0: stay green indefinitely. The counter saturates at GREEN_MAX-1.
- On the GREEN->YELLOW edge, latch next_idx = first k with t[k]=1, searching green_idx+1, +2, ... modulo NUM_DIR.
  - The search excludes green_idx.
  - Sensor changes after this latch do not alter next_idx.
- YELLOW lasts exactly YELLOW_CYCLES cycles, then:
  - go to ALLRED if ALLRED_CYCLES>0;
  - otherwise go directly to GREEN.
- ALLRED lasts exactly ALLRED_CYCLES cycles, then GREEN.
- Entering GREEN: green_idx <= next_idx, and phase_start=1 for that first cycle only.
- Resulting green dwell is GREEN_MIN..GREEN_MAX cycles whenever competing demand exists.
- Sensors sampled only in GREEN; values in YELLOW/ALLRED are ignored.
- rst asserted in any state, including mid-yellow or mid-allred, forces the reset values on the next edge.
- Invariant: at most one direction is non-red in any cycle.

Optional Feature:
- Macro: TRAFFIC_PREEMPT_EN.
- Defined: adds inputs emerg (1 bit) and emerg_dir (width of green_idx).
  - emerg=1 in GREEN with green_idx==emerg_dir: hold green, ignoring GREEN_MAX and other demand.
  - emerg=1 in GREEN with green_idx!=emerg_dir: next edge goes to YELLOW regardless of GREEN_MIN; next_idx <= emerg_dir.
  - emerg=1 in YELLOW or ALLRED: overrides next_idx to emerg_dir. The yellow and all-red timing is never shortened.
- Undefined: ports absent; behaviour exactly as above.

Test Plan:
- Reset, then t=0000 for 20 cycles -> lights=10101000 (dir0 green) throughout, green_idx=0, phase_start never high.
- After reset t=0010 held -> dir0 green 4 cycles, dir0 yellow 2 cycles, all-red 1 cycle, then dir1 green with phase_start pulse; green_idx=1.
- dir1 green, t=1011 held -> max-out after exactly 10 green cycles, then yellow/all-red, then dir3 green; from dir3 the next green is dir0 (wrap-around).
- dir0 green with t=0101, t[0] dropped at cycle 2 -> still green until cycle 4 (GREEN_MIN), then advances to dir2.
- rst pulsed during the 2nd yellow cycle of dir2 -> next cycle lights=10101000, green_idx=0, counter 0.
- TRAFFIC_PREEMPT_EN: dir0 green at cycle 1, emerg=1, emerg_dir=3 -> yellow next cycle (min-green bypassed), 2 yellow + 1 all-red, then dir3 green held while emerg=1 with t=0111 for 30 cycles.
